// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, controller state encoding and the
// GF(2^8) helpers behind the S-box.
package aes_pkg;

  localparam int KEY_W    = 128;
  localparam int NR       = 10;
  localparam int RK_IDX_W = 4;
  localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0), then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/RoundKey.sv
// Single AES-128 key-expansion round: derives round key rnd from round key rnd-1.
module RoundKey
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0]    key_in,
  input  logic [RK_IDX_W-1:0] rnd,
  output logic [KEY_W-1:0]    key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign w0  = key_in[127:96];
  assign w1  = key_in[95:64];
  assign w2  = key_in[63:32];
  assign w3  = key_in[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub[gi*8 +: 8] = sbox(rot[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/key_store.sv
// Eleven-entry round-key register file: one write port, one registered read
// port that returns zero/invalid for indices past the last round key.
module key_store
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [RK_IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [RK_IDX_W-1:0] rd_idx,
  input  logic                rd_qual,
  output logic [KEY_W-1:0]    rd_key,
  output logic                rd_valid
);

  logic [KEY_W-1:0] store_reg [NR+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) store_reg[i] <= '0;
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && (wr_idx <= LAST_IDX)) store_reg[wr_idx] <= wr_data;
      // Read sees pre-edge contents, so a same-edge write is not forwarded.
      if (rd_en) begin
        if (rd_idx <= LAST_IDX) begin
          rd_key   <= store_reg[rd_idx];
          rd_valid <= rd_qual;
        end else begin
          rd_key   <= '0;
          rd_valid <= 1'b0;
        end
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: runs RoundKey over NR cycles after a key
// is accepted and serves the stored schedule through an indexed read port.
module key_sched_ctrl #(
  parameter int KEY_W = aes_pkg::KEY_W,
  parameter int NR    = aes_pkg::NR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_W-1:0]             key_in,
  input  logic                         key_valid,
  output logic                         key_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         keys_valid,
  input  logic                         rd_en,
  input  logic [aes_pkg::RK_IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0]             rd_key,
  output logic                         rd_valid
);

  import aes_pkg::state_t;
  import aes_pkg::ST_IDLE;
  import aes_pkg::ST_EXPAND;
  import aes_pkg::ST_READY;

  localparam int IDX_W = aes_pkg::RK_IDX_W;
  localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NR);

  state_t           state_reg;
  logic [IDX_W-1:0] rnd_reg;
  logic [KEY_W-1:0] cur_reg;
  logic [KEY_W-1:0] key_next;
  logic             key_ready_reg, busy_reg, done_reg, keys_valid_reg;
  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_data;

  assign accept     = key_valid && key_ready_reg;
  assign key_ready  = key_ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign keys_valid = keys_valid_reg;

  RoundKey u_round_key (
    .key_in  (cur_reg),
    .rnd     (rnd_reg),
    .key_out (key_next)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = key_in;
    if (state_reg == ST_EXPAND) begin
      wr_en   = 1'b1;
      wr_idx  = rnd_reg;
      wr_data = key_next;
    end else if (accept) begin
      wr_en = 1'b1;
    end
  end

  key_store u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_qual  (keys_valid_reg),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rnd_reg        <= '0;
      cur_reg        <= '0;
      key_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      keys_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_READY: begin
          if (accept) begin
            state_reg      <= ST_EXPAND;
            cur_reg        <= key_in;
            rnd_reg        <= IDX_W'(1);
            key_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            keys_valid_reg <= 1'b0;
          end
        end
        ST_EXPAND: begin
          cur_reg <= key_next;
          if (rnd_reg == LAST_RND) begin
            state_reg      <= ST_READY;
            rnd_reg        <= '0;
            key_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            keys_valid_reg <= 1'b1;
          end else begin
            rnd_reg <= rnd_reg + IDX_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
